// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Brief    : Shared state encoding and digit indices for the timer front-end.
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET     = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_EXPIRED = 3'd4
  } state_t;

  localparam int NUM_DIGITS = 6;
  localparam int DIG_SU = 0;
  localparam int DIG_ST = 1;
  localparam int DIG_MU = 2;
  localparam int DIG_MT = 3;
  localparam int DIG_HU = 4;
  localparam int DIG_HT = 5;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge
// Brief    : Registered rising-edge detector for one debounced button level.
// Revision : 1.0 - initial release
// ============================================================================
module btn_edge (
  input  logic clk,
  input  logic resetn,
  input  logic btn_i,
  output logic evt_o
);

  logic r_q;
  logic r_arm;
  logic r_evt;

  // r_arm masks the first sample so a button already held at reset release is not an event.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q   <= 1'b0;
      r_arm <= 1'b0;
      r_evt <= 1'b0;
    end else begin
      r_q   <= btn_i;
      r_arm <= 1'b1;
      r_evt <= btn_i & ~r_q & r_arm;
    end
  end

  assign evt_o = r_evt;

endmodule
`default_nettype wire

// File: rtl/timer_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : timer_ctrl_fsm
// Brief    : Button sequencer, run prescaler and blinking alarm for the timer.
// Revision : 1.0 - initial release
// ============================================================================
module timer_ctrl_fsm
  import timer_pkg::*;
#(
  parameter int PRESCALE  = 100000,
  parameter int INC_HOLD  = 101,
  parameter int BLINK     = 25000000,
  parameter int ALARM_LEN = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  btn_mode_i,
  input  logic                  btn_next_i,
  input  logic                  btn_inc_i,
  input  logic                  btn_start_i,
  input  logic                  timer_zero_i,
  output logic [NUM_DIGITS-1:0] set_o,
  output logic                  run_o,
  output logic [2:0]            digit_sel_o,
  output logic [2:0]            state_o,
  output logic                  alarm_o
);

  localparam int c_PW = cnt_width(PRESCALE);
  localparam int c_HW = cnt_width(INC_HOLD);
  localparam int c_BW = cnt_width(BLINK);
  localparam int c_TW = cnt_width(ALARM_LEN);

  localparam logic [c_PW-1:0] c_PRE_LAST   = c_PW'(PRESCALE - 1);
  localparam logic [c_HW-1:0] c_HOLD_LAST  = c_HW'(INC_HOLD - 1);
  localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK - 1);
  localparam logic [c_TW-1:0] c_TOG_LAST   = c_TW'(ALARM_LEN - 1);

  logic w_evt_mode, w_evt_next, w_evt_inc, w_evt_start, w_any_evt;

  btn_edge u_edge_mode  (.clk(clk), .resetn(resetn), .btn_i(btn_mode_i),  .evt_o(w_evt_mode));
  btn_edge u_edge_next  (.clk(clk), .resetn(resetn), .btn_i(btn_next_i),  .evt_o(w_evt_next));
  btn_edge u_edge_inc   (.clk(clk), .resetn(resetn), .btn_i(btn_inc_i),   .evt_o(w_evt_inc));
  btn_edge u_edge_start (.clk(clk), .resetn(resetn), .btn_i(btn_start_i), .evt_o(w_evt_start));

  assign w_any_evt = w_evt_mode | w_evt_next | w_evt_inc | w_evt_start;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_sel, w_sel_nxt;
  logic            r_hold_busy, w_hold_busy_nxt;
  logic [c_HW-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [c_PW-1:0] r_presc, w_presc_nxt;
  logic            r_run, w_run_nxt;
  logic [c_BW-1:0] r_blink, w_blink_nxt;
  logic [c_TW-1:0] r_tog, w_tog_nxt;
  logic            r_alarm, w_alarm_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_hold_busy <= 1'b0;
      r_hold_cnt  <= '0;
      r_presc     <= '0;
      r_run       <= 1'b0;
      r_blink     <= '0;
      r_tog       <= '0;
      r_alarm     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_hold_busy <= w_hold_busy_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_presc     <= w_presc_nxt;
      r_run       <= w_run_nxt;
      r_blink     <= w_blink_nxt;
      r_tog       <= w_tog_nxt;
      r_alarm     <= w_alarm_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_hold_busy_nxt = r_hold_busy;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_presc_nxt     = r_presc;
    w_run_nxt       = 1'b0;
    w_blink_nxt     = r_blink;
    w_tog_nxt       = r_tog;
    w_alarm_nxt     = r_alarm;
    case (r_state)
      ST_IDLE: begin
        if (w_evt_start && !timer_zero_i) begin
          w_state_nxt = ST_RUN;
          w_presc_nxt = '0;
        end else if (w_evt_mode) begin
          w_state_nxt = ST_SET;
          w_sel_nxt   = '0;
        end
      end
      ST_SET: begin
        // While a digit step is being held, every button in SET is swallowed.
        if (r_hold_busy) begin
          if (r_hold_cnt == c_HOLD_LAST) begin
            w_hold_busy_nxt = 1'b0;
            w_hold_cnt_nxt  = '0;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + c_HW'(1);
          end
        end else if (w_evt_mode) begin
          w_state_nxt = ST_IDLE;
        end else if (w_evt_next) begin
          w_sel_nxt = (r_sel == 3'(DIG_HT)) ? 3'(DIG_SU) : r_sel + 3'd1;
        end else if (w_evt_inc) begin
          w_hold_busy_nxt = 1'b1;
          w_hold_cnt_nxt  = '0;
        end
      end
      ST_RUN: begin
        if (timer_zero_i) begin
          w_state_nxt = ST_EXPIRED;
          w_alarm_nxt = 1'b1;
          w_blink_nxt = '0;
          w_tog_nxt   = '0;
        end else if (w_evt_start) begin
          w_state_nxt = ST_PAUSE;
        end else if (r_presc == c_PRE_LAST) begin
          w_presc_nxt = '0;
          w_run_nxt   = 1'b1;
        end else begin
          w_presc_nxt = r_presc + c_PW'(1);
        end
      end
      ST_PAUSE: begin
        if (w_evt_start && !timer_zero_i) begin
          w_state_nxt = ST_RUN;
          w_presc_nxt = '0;
        end else if (w_evt_mode) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXPIRED: begin
        if (w_any_evt) begin
          w_state_nxt = ST_IDLE;
          w_alarm_nxt = 1'b0;
        end else if (r_blink == c_BLINK_LAST) begin
          w_blink_nxt = '0;
          // The final toggle point ends the alarm instead of flipping the output.
          if (r_tog == c_TOG_LAST) begin
            w_state_nxt = ST_IDLE;
            w_alarm_nxt = 1'b0;
            w_tog_nxt   = '0;
          end else begin
            w_alarm_nxt = ~r_alarm;
            w_tog_nxt   = r_tog + c_TW'(1);
          end
        end else begin
          w_blink_nxt = r_blink + c_BW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign set_o       = (r_state == ST_SET && r_hold_busy) ? (NUM_DIGITS'(1) << r_sel) : '0;
  assign run_o       = r_run;
  assign digit_sel_o = r_sel;
  assign state_o     = r_state;
  assign alarm_o     = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_ctrl_fsm
// Brief    : Scoreboard bench for timer_ctrl_fsm with small timing parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_ctrl_fsm;

  localparam int PRESCALE  = 4;
  localparam int INC_HOLD  = 101;
  localparam int BLINK     = 10;
  localparam int ALARM_LEN = 8;

  localparam int B_MODE = 0, B_NEXT = 1, B_INC = 2, B_START = 3;
  localparam int S_STATE = 0, S_SET = 1, S_RUN = 2, S_SEL = 3, S_ALARM = 4, S_MEAS = 5;

  logic       clk = 1'b0;
  logic       resetn;
  logic       btn_mode, btn_next, btn_inc, btn_start, timer_zero;
  logic [5:0] set_o;
  logic       run_o;
  logic [2:0] digit_sel_o;
  logic [2:0] state_o;
  logic       alarm_o;

  timer_ctrl_fsm #(
    .PRESCALE(PRESCALE), .INC_HOLD(INC_HOLD), .BLINK(BLINK), .ALARM_LEN(ALARM_LEN)
  ) dut (
    .clk(clk), .resetn(resetn),
    .btn_mode_i(btn_mode), .btn_next_i(btn_next), .btn_inc_i(btn_inc),
    .btn_start_i(btn_start), .timer_zero_i(timer_zero),
    .set_o(set_o), .run_o(run_o), .digit_sel_o(digit_sel_o),
    .state_o(state_o), .alarm_o(alarm_o)
  );

  always #5 clk = ~clk;

  typedef struct { string name; int sel; int exp; int act; } chk_t;
  typedef struct { int val; int len; } hold_t;

  chk_t  snap_q[$];
  hold_t hold_q[$];
  int    run_q[$];
  int    alarm_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic report(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: drains snapshot expectations and watches set/run/alarm activity.
  chk_t  m_c;
  hold_t m_h;
  int    m_act, m_exp;
  int    run_entry = 0;
  int    set_len = 0, set_val = 0;
  int    alarm_len = 0;
  logic  prev_alarm = 1'b0;
  logic [2:0] prev_state = 3'd0;

  always @(negedge clk) begin
    while (snap_q.size() > 0) begin
      m_c = snap_q.pop_front();
      case (m_c.sel)
        S_STATE: m_act = int'(state_o);
        S_SET:   m_act = int'(set_o);
        S_RUN:   m_act = int'(run_o);
        S_SEL:   m_act = int'(digit_sel_o);
        S_ALARM: m_act = int'(alarm_o);
        default: m_act = m_c.act;
      endcase
      report(m_c.name, m_act, m_c.exp);
    end

    if (!resetn) begin
      set_len = 0;
    end else if (set_o != 6'd0) begin
      if (set_len == 0) set_val = int'(set_o);
      set_len++;
    end else if (set_len > 0) begin
      if (hold_q.size() == 0) begin
        report("set_unexpected", set_len, 0);
      end else begin
        m_h = hold_q.pop_front();
        report("hold_value", set_val, m_h.val);
        report("hold_len", set_len, m_h.len);
      end
      set_len = 0;
    end

    if (state_o == 3'd2 && prev_state != 3'd2) run_entry = cyc;
    if (run_o) begin
      m_exp = (run_q.size() > 0) ? run_q.pop_front() : -1;
      report("run_offset", cyc - run_entry, m_exp);
    end

    if (alarm_o != prev_alarm) begin
      if (prev_state == 3'd4 && state_o == 3'd4) begin
        m_exp = (alarm_q.size() > 0) ? alarm_q.pop_front() : -1;
        report("alarm_phase", alarm_len, m_exp);
      end
      alarm_len = 1;
    end else begin
      alarm_len++;
    end

    prev_alarm = alarm_o;
    prev_state = state_o;
  end

  task automatic chk(input string name, input int sel, input int exp, input int act = 0);
    snap_q.push_back('{name, sel, exp, act});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      B_MODE:  btn_mode  = v;
      B_NEXT:  btn_next  = v;
      B_INC:   btn_inc   = v;
      default: btn_start = v;
    endcase
  endtask

  // Returns one cycle after the FSM has acted on the press.
  task automatic press(input int which);
    set_btn(which, 1'b1);
    tick();
    set_btn(which, 1'b0);
    tick();
  endtask

  int n;
  int wrap_exp[6] = '{3, 4, 5, 0, 1, 2};

  initial begin
    resetn = 1'b0; btn_mode = 0; btn_next = 0; btn_inc = 0; btn_start = 1'b1; timer_zero = 0;

    // 1: reset with start held high
    repeat (3) tick();
    resetn = 1'b1;
    repeat (3) tick();
    chk("rst_state", S_STATE, 0); chk("rst_set", S_SET, 0); chk("rst_run", S_RUN, 0);
    chk("rst_sel", S_SEL, 0);     chk("rst_alarm", S_ALARM, 0);
    btn_start = 1'b0;
    repeat (3) tick();
    chk("held_no_evt", S_STATE, 0);

    // 2: select digit 2 and increment; second inc and next during hold are dropped
    press(B_MODE);
    chk("set_entry", S_STATE, 1); chk("set_sel0", S_SEL, 0);
    press(B_NEXT); press(B_NEXT);
    chk("sel_2", S_SEL, 2);
    hold_q.push_back('{4, 101});
    press(B_INC);
    chk("hold_onehot", S_SET, 4);
    repeat (20) tick();
    press(B_INC);
    press(B_NEXT);
    chk("sel_frozen", S_SEL, 2);
    n = 0;
    while (set_o != 6'd0 && n < 200) begin tick(); n++; end
    chk("hold_done", S_MEAS, 1, int'(set_o == 6'd0));
    chk("set_stay", S_STATE, 1);

    // 3: digit wrap then leave SET
    for (int i = 0; i < 6; i++) begin
      press(B_NEXT);
      chk("wrap_sel", S_SEL, wrap_exp[i]);
    end
    press(B_MODE);
    chk("set_exit", S_STATE, 0); chk("set_exit_set", S_SET, 0);

    // 4: run, pause, resume
    run_q.push_back(4); run_q.push_back(8); run_q.push_back(12);
    press(B_START);
    chk("run_entry", S_STATE, 2);
    repeat (12) tick();
    press(B_START);
    chk("pause", S_STATE, 3); chk("pause_run", S_RUN, 0);
    repeat (10) tick();
    run_q.push_back(4);
    press(B_START);
    chk("resume", S_STATE, 2);
    repeat (6) tick();

    // 5: zero and start event in the same cycle, then full alarm
    btn_start = 1'b1;
    tick();
    timer_zero = 1'b1;
    tick();
    btn_start = 1'b0;
    for (int i = 0; i < ALARM_LEN - 1; i++) alarm_q.push_back(10);
    chk("zero_wins", S_STATE, 4); chk("alarm_on", S_ALARM, 1); chk("exp_run", S_RUN, 0);
    n = 0;
    while (state_o != 3'd0 && n < 200) begin tick(); n++; end
    chk("alarm_dur", S_MEAS, 80, n);
    chk("alarm_off", S_ALARM, 0);

    // 6: start ignored at zero, alarm cut short, async reset mid-hold
    press(B_START);
    chk("zero_start_ign", S_STATE, 0);
    timer_zero = 1'b0;
    press(B_START);
    chk("run_again", S_STATE, 2);
    timer_zero = 1'b1;
    tick();
    chk("expired_again", S_STATE, 4); chk("alarm_again", S_ALARM, 1);
    repeat (3) tick();
    press(B_MODE);
    chk("btn_abort", S_STATE, 0); chk("btn_abort_alarm", S_ALARM, 0);
    timer_zero = 1'b0;
    press(B_MODE);
    press(B_INC);
    chk("hold2", S_SET, 1);
    repeat (5) tick();
    resetn = 1'b0;
    chk("async_set", S_SET, 0); chk("async_state", S_STATE, 0); chk("async_alarm", S_ALARM, 0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    chk("run_q_left", S_MEAS, 0, run_q.size());
    chk("hold_q_left", S_MEAS, 0, hold_q.size());
    chk("alarm_q_left", S_MEAS, 0, alarm_q.size());
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
`default_nettype wire
